// File: rtl/dl_demux2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dl_demux2_pkg
//  Purpose  : Shared types and helpers for the dl_demux2 stream demultiplexer
//             and its 2-entry FIFO channels.
//  Contents : cnt_t occupancy type, occupancy constants, f_next_count helper.
//  Revision : 1.0 - initial release
// ============================================================================
package dl_demux2_pkg;

   // Occupancy of a 2-entry buffer: 0, 1 or 2.
   typedef logic [1:0] cnt_t;

   localparam cnt_t C_CNT_EMPTY = 2'd0;
   localparam cnt_t C_CNT_FULL  = 2'd2;

   // Next occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
   function automatic cnt_t f_next_count(input cnt_t cnt, input logic push, input logic pop);
      cnt_t nxt;
      nxt = cnt;
      case ({push, pop})
         2'b10:   nxt = cnt + 2'd1;
         2'b01:   nxt = cnt - 2'd1;
         default: nxt = cnt;
      endcase
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dl_fifo2.sv
`default_nettype none
// ============================================================================
//  Module   : dl_fifo2
//  Purpose  : 2-entry synchronous FIFO with registered occupancy and 1-bit
//             read/write pointers. No bypass: a pushed word is visible on
//             pop_data from the cycle after the push.
//  Ports    : clk, rst_n     - clock, asynchronous active-low reset
//             push/push_data - write strobe and word (ignored when full)
//             full           - occupancy is 2
//             pop            - read strobe (ignored when empty)
//             pop_data       - word at the read pointer
//             empty          - occupancy is 0
//  Revision : 1.0 - initial release
// ============================================================================
module dl_fifo2
   import dl_demux2_pkg::*;
#(
   parameter int NUM_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [NUM_BITS-1:0] push_data,
   output logic                full,
   input  logic                pop,
   output logic [NUM_BITS-1:0] pop_data,
   output logic                empty
);

   logic [NUM_BITS-1:0] r_mem [2];
   cnt_t                r_count;
   logic                r_wptr;
   logic                r_rptr;

   logic w_push;
   logic w_pop;

   // Guard strobes locally so a misbehaving parent cannot overrun or underrun.
   assign w_push = push & ~full;
   assign w_pop  = pop  & ~empty;

   assign full     = (r_count == C_CNT_FULL);
   assign empty    = (r_count == C_CNT_EMPTY);
   assign pop_data = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= C_CNT_EMPTY;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
      end else begin
         r_count <= f_next_count(r_count, w_push, w_pop);
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
      end
   end

   // Storage is deliberately not reset; contents are only meaningful while
   // the occupancy says so.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/dl_demux2.sv
`default_nettype none
// ============================================================================
//  Module   : dl_demux2
//  Purpose  : 1-to-2 valid/ready stream demultiplexer. Each accepted input
//             word is routed by in_sel into a 2-entry buffer per output.
//  Ports    : clk, rst_n                      - clock, async active-low reset
//             in_valid/in_ready/in_data/in_sel - input stream and destination
//             out0_valid/out0_ready/out0_data  - output stream 0
//             out1_valid/out1_ready/out1_data  - output stream 1
//  Revision : 1.0 - initial release
// ============================================================================
module dl_demux2 #(
   parameter int NUM_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] in_data,
   input  logic                in_sel,
   output logic                out0_valid,
   input  logic                out0_ready,
   output logic [NUM_BITS-1:0] out0_data,
   output logic                out1_valid,
   input  logic                out1_ready,
   output logic [NUM_BITS-1:0] out1_data
);

   logic w_full0;
   logic w_full1;
   logic w_empty0;
   logic w_empty1;
   logic w_push0;
   logic w_push1;
   logic w_pop0;
   logic w_pop1;

   // Ready depends only on the selected channel, so a stalled consumer never
   // blocks words headed to the other output.
   assign in_ready = in_sel ? ~w_full1 : ~w_full0;

   assign w_push0 = in_valid & ~in_sel & ~w_full0;
   assign w_push1 = in_valid &  in_sel & ~w_full1;

   assign out0_valid = ~w_empty0;
   assign out1_valid = ~w_empty1;
   assign w_pop0     = out0_ready & ~w_empty0;
   assign w_pop1     = out1_ready & ~w_empty1;

   dl_fifo2 #(
      .NUM_BITS (NUM_BITS)
   ) u_fifo0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push0),
      .push_data (in_data),
      .full      (w_full0),
      .pop       (w_pop0),
      .pop_data  (out0_data),
      .empty     (w_empty0)
   );

   dl_fifo2 #(
      .NUM_BITS (NUM_BITS)
   ) u_fifo1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push1),
      .push_data (in_data),
      .full      (w_full1),
      .pop       (w_pop1),
      .pop_data  (out1_data),
      .empty     (w_empty1)
   );

endmodule
`default_nettype wire
